// File: rtl/eth_pkt_fifo_rd_ctrl.sv
// Read-side controller for the Ethernet packet FIFO: drains committed packets
// from a combinational-read RAM into a valid/ready byte stream with tlast.
module eth_pkt_fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IPG_CYCLES = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   commit_ptr,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH:0]   mem_rd_data,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  input  logic                  flush,
  output logic [15:0]           pkt_cnt,
  output logic                  underrun_err
);

  // The IDLE cycle that loads the next first word is the final gap clock,
  // so GAP itself only lasts IPG_CYCLES-1 clocks.
  localparam int GW       = (IPG_CYCLES > 2) ? $clog2(IPG_CYCLES - 1) : 1;
  localparam int GAP_LAST = (IPG_CYCLES > 1) ? IPG_CYCLES - 2 : 0;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
  logic            avail, accept, accept_last, hold_last, load, underrun_set;

  assign mem_rd_addr = rd_ptr[ADDR_WIDTH-1:0];
  assign avail       = (commit_ptr != rd_ptr);
  assign accept      = m_tvalid && m_tready;
  assign accept_last = accept && m_tlast;
  assign hold_last   = m_tvalid && m_tlast && !m_tready;

  always_comb begin
    state_nxt    = state;
    gap_cnt_nxt  = gap_cnt;
    load         = 1'b0;
    underrun_set = 1'b0;
    case (state)
      IDLE: begin
        if (avail && (!m_tvalid || m_tready)) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (accept_last && (IPG_CYCLES > 0)) begin
          state_nxt   = (IPG_CYCLES > 1) ? GAP : IDLE;
          gap_cnt_nxt = '0;
        end else begin
          load = avail && (!m_tvalid || m_tready) && !hold_last;
          if (accept_last && !load) state_nxt = IDLE;
          if (!avail && !hold_last && !m_tvalid) underrun_set = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_LAST)) begin
          state_nxt   = IDLE;
          gap_cnt_nxt = '0;
        end else begin
          gap_cnt_nxt = gap_cnt + GW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt    = IDLE;
      gap_cnt_nxt  = '0;
      load         = 1'b0;
      underrun_set = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      m_tdata      <= '0;
      m_tvalid     <= 1'b0;
      m_tlast      <= 1'b0;
      pkt_cnt      <= '0;
      underrun_err <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr   <= commit_ptr;
        m_tvalid <= 1'b0;
        m_tlast  <= 1'b0;
      end else if (load) begin
        m_tdata  <= mem_rd_data[DATA_WIDTH-1:0];
        m_tlast  <= mem_rd_data[DATA_WIDTH];
        m_tvalid <= 1'b1;
        rd_ptr   <= rd_ptr + (ADDR_WIDTH+1)'(1);
      end else if (accept) begin
        m_tvalid <= 1'b0;
      end
      if (!flush && accept_last) pkt_cnt <= pkt_cnt + 16'd1;
      if (underrun_set) underrun_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eth_pkt_fifo_rd_ctrl.sv
// Directed bench for eth_pkt_fifo_rd_ctrl: one instance with a 12-clock gap,
// one with IPG_CYCLES=0 for back-to-back packets, sharing a RAM model.
module tb_eth_pkt_fifo_rd_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW:0] ram [0:15];

  logic [AW:0]   commit_ptr, rd_ptr;
  logic [AW-1:0] mem_rd_addr;
  logic [DW:0]   mem_rd_data;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast, m_tready, flush, underrun_err;
  logic [15:0]   pkt_cnt;

  logic [AW:0]   c0_commit, c0_rd_ptr;
  logic [AW-1:0] c0_addr;
  logic [DW:0]   c0_rd_data;
  logic [DW-1:0] c0_tdata;
  logic          c0_tvalid, c0_tlast, c0_tready, c0_flush, c0_underrun;
  logic [15:0]   c0_pkt_cnt;

  assign mem_rd_data = ram[mem_rd_addr];
  assign c0_rd_data  = ram[c0_addr];

  eth_pkt_fifo_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IPG_CYCLES(12)) dut (
    .clk(clk), .rst_n(rst_n), .commit_ptr(commit_ptr), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .rd_ptr(rd_ptr), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tlast(m_tlast), .m_tready(m_tready), .flush(flush), .pkt_cnt(pkt_cnt),
    .underrun_err(underrun_err));

  eth_pkt_fifo_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IPG_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .commit_ptr(c0_commit), .mem_rd_addr(c0_addr),
    .mem_rd_data(c0_rd_data), .rd_ptr(c0_rd_ptr), .m_tdata(c0_tdata), .m_tvalid(c0_tvalid),
    .m_tlast(c0_tlast), .m_tready(c0_tready), .flush(c0_flush), .pkt_cnt(c0_pkt_cnt),
    .underrun_err(c0_underrun));

  int vec = 0;
  int err = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW:0] w(input logic [DW-1:0] d, input logic l);
    return {l, d};
  endfunction

  task automatic test_reset;
    #12;
    vec++; if (m_tvalid !== 1'b0) begin err++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    vec++; if (m_tdata !== 8'h00) begin err++; $display("FAIL reset_tdata: got %h want 00", m_tdata); end
    vec++; if (m_tlast !== 1'b0) begin err++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
    vec++; if (rd_ptr !== 5'd0) begin err++; $display("FAIL reset_rd_ptr: got %0d want 0", rd_ptr); end
    vec++; if (pkt_cnt !== 16'd0) begin err++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
    vec++; if (underrun_err !== 1'b0) begin err++; $display("FAIL reset_underrun: got %b want 0", underrun_err); end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single_packet;
    int idle;
    bit seen;
    ram[0] = w(8'hA0, 0); ram[1] = w(8'hA1, 0); ram[2] = w(8'hA2, 0); ram[3] = w(8'hA3, 1);
    m_tready   = 1'b1;
    commit_ptr = 5'd4;
    for (int i = 0; i < 4; i++) begin
      tick;
      vec++;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'hA0 + 8'(i) || m_tlast !== (i == 3)) begin
        err++;
        $display("FAIL single_word%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, m_tvalid, m_tdata, m_tlast, 8'hA0 + 8'(i), (i == 3));
      end
    end
    tick;
    vec++; if (m_tvalid !== 1'b0) begin err++; $display("FAIL single_end_tvalid: got %b want 0", m_tvalid); end
    vec++; if (rd_ptr !== 5'd4) begin err++; $display("FAIL single_rd_ptr: got %0d want 4", rd_ptr); end
    vec++; if (pkt_cnt !== 16'd1) begin err++; $display("FAIL single_pkt_cnt: got %0d want 1", pkt_cnt); end
    // second packet is already committed while the gap runs
    ram[4] = w(8'hB0, 0); ram[5] = w(8'hB1, 1);
    commit_ptr = 5'd6;
    idle = 1;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      tick;
      if (m_tvalid) begin seen = 1; break; end
      idle++;
    end
    vec++;
    if (!seen || idle != 12) begin
      err++; $display("FAIL ipg_idle_clks: got %0d (seen=%0d) want 12", idle, seen);
    end
    vec++; if (m_tdata !== 8'hB0) begin err++; $display("FAIL ipg_first: got %h want B0", m_tdata); end
    tick;
    vec++;
    if (m_tdata !== 8'hB1 || m_tlast !== 1'b1) begin
      err++; $display("FAIL ipg_second: got d=%h l=%b want d=B1 l=1", m_tdata, m_tlast);
    end
    tick;
    vec++; if (pkt_cnt !== 16'd2) begin err++; $display("FAIL ipg_pkt_cnt: got %0d want 2", pkt_cnt); end
    vec++; if (rd_ptr !== 5'd6) begin err++; $display("FAIL ipg_rd_ptr: got %0d want 6", rd_ptr); end
    repeat (15) tick;
  endtask

  task automatic test_backpressure;
    logic [6:0] pat;
    logic [DW:0] got [$];
    logic [DW:0] exp_w [4];
    logic [DW:0] pd;
    logic pv, pr;
    pat = 7'b1101001;
    exp_w[0] = w(8'hC0, 0); exp_w[1] = w(8'hC1, 0); exp_w[2] = w(8'hC2, 0); exp_w[3] = w(8'hC3, 1);
    for (int k = 0; k < 4; k++) ram[6+k] = exp_w[k];
    commit_ptr = 5'd10;
    pv = 0; pr = 1; pd = '0;
    for (int i = 0; i < 20; i++) begin
      m_tready = (i < 7) ? pat[i] : 1'b1;
      if (pv && !pr) begin
        vec++;
        if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== pd) begin
          err++; $display("FAIL stall_hold cyc%0d: got v=%b w=%h want v=1 w=%h", i, m_tvalid, {m_tlast, m_tdata}, pd);
        end
      end
      if (m_tvalid && m_tready) got.push_back({m_tlast, m_tdata});
      pv = m_tvalid; pr = m_tready; pd = {m_tlast, m_tdata};
      tick;
    end
    vec++;
    if (got.size() != 4) begin
      err++; $display("FAIL bp_word_count: got %0d want 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        vec++;
        if (got[k] !== exp_w[k]) begin err++; $display("FAIL bp_word%0d: got %h want %h", k, got[k], exp_w[k]); end
      end
    end
    vec++; if (rd_ptr !== 5'd10) begin err++; $display("FAIL bp_rd_ptr: got %0d want 10", rd_ptr); end
    vec++; if (pkt_cnt !== 16'd3) begin err++; $display("FAIL bp_pkt_cnt: got %0d want 3", pkt_cnt); end
    m_tready = 1'b1;
    repeat (15) tick;
  endtask

  task automatic test_wrap;
    logic [AW-1:0] addrs [$];
    logic [DW:0]   datas [$];
    logic [AW-1:0] exp_a [5];
    logic [DW:0]   exp_d [5];
    commit_ptr = 5'd14;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    vec++; if (rd_ptr !== 5'd14) begin err++; $display("FAIL wrap_preset: got %0d want 14", rd_ptr); end
    exp_a[0] = 4'd14; exp_a[1] = 4'd15; exp_a[2] = 4'd0; exp_a[3] = 4'd1; exp_a[4] = 4'd2;
    for (int k = 0; k < 5; k++) begin
      exp_d[k] = w(8'hD0 + 8'(k), k == 4);
      ram[exp_a[k]] = exp_d[k];
    end
    commit_ptr = 5'd19;
    for (int i = 0; i < 12; i++) begin
      if (commit_ptr !== rd_ptr) addrs.push_back(mem_rd_addr);
      if (m_tvalid && m_tready) datas.push_back({m_tlast, m_tdata});
      tick;
    end
    vec++;
    if (addrs.size() != 5 || datas.size() != 5) begin
      err++; $display("FAIL wrap_count: got a=%0d d=%0d want 5 5", addrs.size(), datas.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        vec++;
        if (addrs[k] !== exp_a[k] || datas[k] !== exp_d[k]) begin
          err++; $display("FAIL wrap_word%0d: got a=%0d w=%h want a=%0d w=%h", k, addrs[k], datas[k], exp_a[k], exp_d[k]);
        end
      end
    end
    vec++; if (rd_ptr !== 5'b10011) begin err++; $display("FAIL wrap_rd_ptr: got %b want 10011", rd_ptr); end
    vec++; if (pkt_cnt !== 16'd4) begin err++; $display("FAIL wrap_pkt_cnt: got %0d want 4", pkt_cnt); end
    repeat (15) tick;
  endtask

  task automatic test_flush;
    for (int k = 0; k < 6; k++) ram[3+k] = w(8'hE0 + 8'(k), k == 5);
    commit_ptr = 5'd25;
    repeat (3) tick;
    vec++; if (m_tdata !== 8'hE2 || m_tvalid !== 1'b1) begin err++; $display("FAIL flush_pre: got v=%b d=%h want v=1 d=E2", m_tvalid, m_tdata); end
    flush = 1'b1;
    tick;
    flush = 1'b0;
    vec++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin err++; $display("FAIL flush_out: got v=%b l=%b want 0 0", m_tvalid, m_tlast); end
    vec++; if (rd_ptr !== 5'd25) begin err++; $display("FAIL flush_rd_ptr: got %0d want 25", rd_ptr); end
    vec++; if (pkt_cnt !== 16'd4) begin err++; $display("FAIL flush_pkt_cnt: got %0d want 4", pkt_cnt); end
    repeat (3) tick;
    vec++; if (m_tvalid !== 1'b0) begin err++; $display("FAIL flush_idle: got %b want 0", m_tvalid); end
  endtask

  task automatic test_underrun;
    int n;
    vec++; if (underrun_err !== 1'b0) begin err++; $display("FAIL underrun_pre: got %b want 0", underrun_err); end
    for (int k = 0; k < 3; k++) ram[9+k] = w(8'hF0 + 8'(k), 0);
    commit_ptr = 5'd28;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_tvalid && m_tready) n++;
      tick;
    end
    vec++; if (n != 3) begin err++; $display("FAIL underrun_words: got %0d want 3", n); end
    vec++; if (underrun_err !== 1'b1) begin err++; $display("FAIL underrun_set: got %b want 1", underrun_err); end
    flush = 1'b1;
    tick;
    flush = 1'b0;
    repeat (3) tick;
    vec++; if (underrun_err !== 1'b1) begin err++; $display("FAIL underrun_sticky: got %b want 1", underrun_err); end
  endtask

  task automatic test_midstream_reset;
    for (int k = 0; k < 4; k++) ram[12+k] = w(8'h60 + 8'(k), k == 3);
    commit_ptr = 5'd0;
    repeat (2) tick;
    vec++; if (m_tvalid !== 1'b1 || m_tdata !== 8'h61) begin err++; $display("FAIL midrst_pre: got v=%b d=%h want v=1 d=61", m_tvalid, m_tdata); end
    #2 rst_n = 1'b0;
    #1;
    vec++; if (m_tvalid !== 1'b0 || m_tdata !== 8'h00 || m_tlast !== 1'b0) begin
      err++; $display("FAIL midrst_out: got v=%b d=%h l=%b want 0 00 0", m_tvalid, m_tdata, m_tlast);
    end
    vec++; if (rd_ptr !== 5'd0) begin err++; $display("FAIL midrst_rd_ptr: got %0d want 0", rd_ptr); end
    vec++; if (pkt_cnt !== 16'd0 || underrun_err !== 1'b0) begin
      err++; $display("FAIL midrst_stat: got cnt=%0d u=%b want 0 0", pkt_cnt, underrun_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_back_to_back;
    logic [DW:0] exp_w [5];
    exp_w[0] = w(8'h70, 0); exp_w[1] = w(8'h71, 1);
    exp_w[2] = w(8'h80, 0); exp_w[3] = w(8'h81, 0); exp_w[4] = w(8'h82, 1);
    for (int k = 0; k < 5; k++) ram[k] = exp_w[k];
    c0_tready = 1'b1;
    c0_commit = 5'd5;
    tick;
    for (int k = 0; k < 5; k++) begin
      vec++;
      if (c0_tvalid !== 1'b1 || {c0_tlast, c0_tdata} !== exp_w[k]) begin
        err++; $display("FAIL b2b_word%0d: got v=%b w=%h want v=1 w=%h", k, c0_tvalid, {c0_tlast, c0_tdata}, exp_w[k]);
      end
      tick;
    end
    vec++; if (c0_tvalid !== 1'b0) begin err++; $display("FAIL b2b_end: got %b want 0", c0_tvalid); end
    vec++; if (c0_pkt_cnt !== 16'd2) begin err++; $display("FAIL b2b_pkt_cnt: got %0d want 2", c0_pkt_cnt); end
    vec++; if (c0_rd_ptr !== 5'd5) begin err++; $display("FAIL b2b_rd_ptr: got %0d want 5", c0_rd_ptr); end
    vec++; if (c0_underrun !== 1'b0) begin err++; $display("FAIL b2b_underrun: got %b want 0", c0_underrun); end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) ram[k] = '0;
    commit_ptr = '0; m_tready = 1'b0; flush = 1'b0;
    c0_commit = '0; c0_tready = 1'b0; c0_flush = 1'b0;
    test_reset;
    test_single_packet;
    test_backpressure;
    test_wrap;
    test_flush;
    test_underrun;
    test_midstream_reset;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
